// File: rtl/int_mac_unit_pkg.sv
// Shared types for the integer multiply/accumulate unit: token layouts,
// packed opcode, pipeline stage token and the attribute-drop FSM states.
package int_mac_unit_pkg;

   localparam int WIDTH_COND = 3;
   localparam int WIDTH_TK   = 32;

   typedef logic [(1 << WIDTH_COND) - 1:0] cond_t;

   typedef struct packed {
      logic                v;
      logic                a;
      logic                c;
      logic                r;
      logic [WIDTH_TK-1:0] d;
   } FTk_t;

   typedef struct packed {
      logic n;
      logic t;
      logic v;
      logic c;
   } BTk_t;

   typedef struct packed {
      logic outCondF;
      logic outCondB;
      logic accumulate;
      logic highSel;
      logic saturate;
      logic signedMode;
   } opcode_mac_t;

   // Token travelling down the pipeline with its sampled mode bits.
   typedef struct packed {
      FTk_t                  tk;
      logic                  sign;
      logic                  cond;
      opcode_mac_t           op;
      logic [2*WIDTH_TK-1:0] mag;
   } mac_stage_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_RUN
   } mac_state_t;

endpackage

// File: rtl/int_mac_unit_pprod.sv
// First pipeline stage logic: operand magnitudes and the four
// half-width partial products of the magnitude multiply.
module int_mac_pprod #(
   parameter int WIDTH_DATA = 32
) (
   input  logic                  signedMode,
   input  logic [WIDTH_DATA-1:0] operandA,
   input  logic [WIDTH_DATA-1:0] operandB,
   output logic                  sign,
   output logic [WIDTH_DATA-1:0] ppLL,
   output logic [WIDTH_DATA-1:0] ppLH,
   output logic [WIDTH_DATA-1:0] ppHL,
   output logic [WIDTH_DATA-1:0] ppHH
);

   localparam int H = WIDTH_DATA / 2;

   logic [WIDTH_DATA-1:0]      magA;
   logic [WIDTH_DATA-1:0]      magB;
   logic [1:0][H-1:0]          halfA;
   logic [1:0][H-1:0]          halfB;
   logic [3:0][WIDTH_DATA-1:0] pp;

   // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
   assign magA  = (signedMode & operandA[WIDTH_DATA-1]) ? -operandA : operandA;
   assign magB  = (signedMode & operandB[WIDTH_DATA-1]) ? -operandB : operandB;
   assign sign  = signedMode & (operandA[WIDTH_DATA-1] ^ operandB[WIDTH_DATA-1]);
   assign halfA = magA;
   assign halfB = magB;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pp
         assign pp[gi] = {{H{1'b0}}, halfA[gi / 2]} * {{H{1'b0}}, halfB[gi % 2]};
      end
   endgenerate

   assign ppLL = pp[0];
   assign ppLH = pp[1];
   assign ppHL = pp[2];
   assign ppHH = pp[3];

endmodule

// File: rtl/int_mac_unit.sv
// Three-stage stallable integer multiply/MAC with header drop and saturation.
// Define INT_MAC_ACC_EN to build the accumulator and accumulate mode.
module int_mac_unit
   import int_mac_unit_pkg::*;
#(
   parameter int WIDTH_DATA = WIDTH_TK,
   parameter int WIDTH_ACC  = 2 * WIDTH_DATA
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        I_En,
   input  opcode_mac_t I_Opcode,
   input  cond_t       I_Cond,
   input  FTk_t        I_OperandA,
   input  FTk_t        I_OperandB,
   output FTk_t        O_Result,
   input  BTk_t        I_BTk,
   output BTk_t        O_BTk
);

   localparam int W  = WIDTH_DATA;
   localparam int H  = WIDTH_DATA / 2;
   localparam int W2 = 2 * WIDTH_DATA;

   mac_state_t            stateReg, stateNext;
   logic                  enPrevReg;
   logic                  adv, accept, dropPair;
   mac_stage_t            s1Reg, s1Next, s2Reg, s2Next, s3Reg, s3Next;
   logic [3:0][W-1:0]     ppReg, ppNext;
   logic                  pSign;
   logic [W:0]            midSum;
   logic [W2-1:0]         prodMag, prodSigned;
   logic [WIDTH_ACC-1:0]  prodExt, accValue;
   logic [W-1:0]          selWord, dOut;
   logic                  overflowed, condBit;
   logic [WIDTH_COND-1:0] condIdx;

   // The whole pipeline freezes only when a valid result is being held back.
   assign adv    = ~(I_BTk.n & s3Reg.tk.v);
   assign accept = I_En & I_OperandA.v & I_OperandB.v & adv;

   always_comb begin
      stateNext = stateReg;
      dropPair  = 1'b1;
      if (!I_En) begin
         stateNext = ST_IDLE;
      end else begin
         case (stateReg)
            ST_IDLE: if (!enPrevReg) stateNext = ST_HDR;
            ST_HDR:  if (accept) stateNext = ST_RUN;
            ST_RUN:  dropPair = 1'b0;
            default: stateNext = ST_IDLE;
         endcase
         if (accept && I_OperandA.r) stateNext = ST_IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateReg  <= ST_IDLE;
         enPrevReg <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         enPrevReg <= I_En;
      end
   end

   int_mac_pprod #(.WIDTH_DATA(W)) u_pprod (
      .signedMode (I_Opcode.signedMode),
      .operandA   (I_OperandA.d[W-1:0]),
      .operandB   (I_OperandB.d[W-1:0]),
      .sign       (pSign),
      .ppLL       (ppNext[0]),
      .ppLH       (ppNext[1]),
      .ppHL       (ppNext[2]),
      .ppHH       (ppNext[3])
   );

   always_comb begin
      s1Next = '0;
      if (accept && !dropPair) begin
         s1Next.tk.v = 1'b1;
         s1Next.tk.c = I_OperandA.c;
         s1Next.tk.r = I_OperandA.r;
         s1Next.sign = pSign;
         s1Next.op   = I_Opcode;
      end
   end

   assign midSum  = {1'b0, ppReg[1]} + {1'b0, ppReg[2]};
   assign prodMag = W2'(ppReg[0]) + (W2'(midSum) << H) + (W2'(ppReg[3]) << W);

   always_comb begin
      s2Next     = s1Reg;
      s2Next.mag = s1Reg.tk.v ? prodMag : '0;
   end

`ifdef INT_MAC_ACC_EN
   logic [WIDTH_ACC-1:0] accReg;
   logic [WIDTH_ACC-1:0] accSum;

   assign accSum = accReg + prodExt;

   always_ff @(posedge clock) begin
      if (reset) begin
         accReg <= '0;
      end else if (adv && s2Reg.tk.v && s2Reg.op.accumulate) begin
         accReg <= s2Reg.tk.r ? '0 : accSum;
      end
   end
`endif

   always_comb begin
      prodSigned = s2Reg.sign ? -s2Reg.mag : s2Reg.mag;
      if (s2Reg.op.signedMode) prodExt = WIDTH_ACC'($signed(prodSigned));
      else                     prodExt = WIDTH_ACC'(prodSigned);
`ifdef INT_MAC_ACC_EN
      accValue = s2Reg.op.accumulate ? accSum : prodExt;
`else
      accValue = prodExt;
`endif
      if (s2Reg.op.signedMode)
         overflowed = ~((&accValue[WIDTH_ACC-1:W-1]) | ~(|accValue[WIDTH_ACC-1:W-1]));
      else
         overflowed = |accValue[WIDTH_ACC-1:W];
      selWord = s2Reg.op.highSel ? accValue[W2-1:W] : accValue[W-1:0];
      dOut    = selWord;
      if (!s2Reg.op.highSel && s2Reg.op.saturate && overflowed) begin
         if (!s2Reg.op.signedMode)       dOut = '1;
         else if (accValue[WIDTH_ACC-1]) dOut = {1'b1, {(W-1){1'b0}}};
         else                            dOut = {1'b0, {(W-1){1'b1}}};
      end
      condIdx     = {selWord[W-1], overflowed, dOut == '0};
      condBit     = I_Cond[condIdx];
      s3Next      = s2Reg;
      s3Next.tk.d = dOut;
      s3Next.tk.c = s2Reg.op.outCondF ? condBit : s2Reg.tk.c;
      s3Next.cond = condBit;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1Reg <= '0;
         s2Reg <= '0;
         s3Reg <= '0;
         ppReg <= '0;
      end else if (adv) begin
         s1Reg <= s1Next;
         s2Reg <= s2Next;
         s3Reg <= s3Next;
         ppReg <= ppNext;
      end
   end

   assign O_Result = s3Reg.tk;

   always_comb begin
      O_BTk   = I_BTk;
      O_BTk.n = ~adv;
      if (s3Reg.op.outCondB) begin
         O_BTk.v = s3Reg.tk.c;
         O_BTk.c = s3Reg.cond;
      end
   end

endmodule

// File: tb/tb_int_mac_unit.sv
// Directed bench for int_mac_unit; expected values are hand-computed.
module tb_int_mac_unit;
   import int_mac_unit_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        I_En;
   opcode_mac_t I_Opcode;
   cond_t       I_Cond;
   FTk_t        I_OperandA, I_OperandB, O_Result;
   BTk_t        I_BTk, O_BTk;

   int errors = 0;
   int checks = 0;
   logic [31:0] qd[$];
   logic        qc[$];

   localparam logic [5:0] OP_UL   = 6'b000000;
   localparam logic [5:0] OP_UH   = 6'b000100;
   localparam logic [5:0] OP_USF  = 6'b100010;
   localparam logic [5:0] OP_SF   = 6'b100001;
   localparam logic [5:0] OP_SH   = 6'b000101;
   localparam logic [5:0] OP_SS   = 6'b000011;
   localparam logic [5:0] OP_ACC  = 6'b001000;
`ifdef INT_MAC_ACC_EN
   localparam logic [31:0] ACC_SECOND = 32'd26;
`else
   localparam logic [31:0] ACC_SECOND = 32'd20;
`endif

   always #5 clock = ~clock;

   int_mac_unit #(.WIDTH_DATA(32), .WIDTH_ACC(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .I_En       (I_En),
      .I_Opcode   (I_Opcode),
      .I_Cond     (I_Cond),
      .I_OperandA (I_OperandA),
      .I_OperandB (I_OperandB),
      .O_Result   (O_Result),
      .I_BTk      (I_BTk),
      .O_BTk      (O_BTk)
   );

   // Records every result handed downstream (valid and not stalled).
   always @(negedge clock) begin
      if (!reset && O_Result.v && !I_BTk.n) begin
         qd.push_back(O_Result.d);
         qc.push_back(O_Result.c);
         $display("out d=%08h c=%0b t=%0t", O_Result.d, O_Result.c, $time);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] op, input logic r, input logic c);
      I_OperandA.v = v; I_OperandA.a = 1'b0; I_OperandA.c = c;    I_OperandA.r = r;    I_OperandA.d = a;
      I_OperandB.v = v; I_OperandB.a = 1'b0; I_OperandB.c = 1'b0; I_OperandB.r = 1'b0; I_OperandB.d = b;
      I_Opcode = op;
   endtask

   task automatic idle();
      drive(1'b0, 32'd0, 32'd0, OP_UL, 1'b0, 1'b0);
   endtask

   task automatic expectOut(input string tag, input logic [31:0] expD, input logic expC);
      logic [31:0] d;
      logic        c;
      d = 'x;
      c = 'x;
      if (qd.size() > 0) begin
         d = qd.pop_front();
         c = qc.pop_front();
      end
      check({tag, ".d"}, d, expD);
      check({tag, ".c"}, c, expC);
   endtask

   initial begin
      reset = 1'b1;
      I_En  = 1'b0;
      I_Cond = '0;
      I_BTk.n = 1'b0; I_BTk.t = 1'b1; I_BTk.v = 1'b1; I_BTk.c = 1'b1;
      idle();
      tick(); tick(); tick();
      check("rst.result", O_Result, 64'd0);
      check("rst.btk", O_BTk, 64'h7);
      I_BTk = '0;
      reset = 1'b0;
      tick();

      // Header drop and latency
      I_En = 1'b1;
      tick();
      drive(1'b1, 32'd5, 32'd5, OP_UL, 1'b0, 1'b0); tick();
      drive(1'b1, 32'd2, 32'd3, OP_UL, 1'b0, 1'b0); tick();
      idle();
      check("hdr.v1", O_Result.v, 64'd0); tick();
      check("hdr.v2", O_Result.v, 64'd0); tick();
      check("hdr.v3", O_Result.v, 64'd1);
      check("hdr.d3", O_Result.d, 64'h6);
      tick(); tick();
      expectOut("hdr", 32'h6, 1'b0);
      check("hdr.count", qd.size(), 64'd0);

      // Unsigned full-scale square
      I_Cond = 8'h04;
      drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_UL,  1'b0, 1'b1); tick();
      drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_UH,  1'b0, 1'b0); tick();
      drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_USF, 1'b0, 1'b0); tick();
      idle(); tick(); tick(); tick();
      expectOut("u.low",  32'h00000001, 1'b1);
      expectOut("u.high", 32'hFFFFFFFE, 1'b0);
      expectOut("u.sat",  32'hFFFFFFFF, 1'b1);

      // Signed products and saturation
      I_Cond = 8'h10;
      drive(1'b1, 32'hFFFFFFFD, 32'd7, OP_SF, 1'b0, 1'b0); tick();
      drive(1'b1, 32'hFFFFFFFD, 32'd7, OP_SH, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h40000000, 32'd4, OP_SS, 1'b0, 1'b0); tick();
      drive(1'b1, 32'hC0000000, 32'd4, OP_SS, 1'b0, 1'b0); tick();
      idle(); tick(); tick(); tick();
      expectOut("s.low",  32'hFFFFFFEB, 1'b1);
      expectOut("s.high", 32'hFFFFFFFF, 1'b0);
      expectOut("s.satp", 32'h7FFFFFFF, 1'b0);
      expectOut("s.satn", 32'h80000000, 1'b0);

      // Accumulate across a terminated stream, then a fresh stream
      I_Cond = 8'h00;
      drive(1'b1, 32'd2, 32'd3, OP_ACC, 1'b0, 1'b0); tick();
      drive(1'b1, 32'd4, 32'd5, OP_ACC, 1'b1, 1'b0); tick();
      idle();
      I_En = 1'b0; tick();
      I_En = 1'b1; tick();
      drive(1'b1, 32'd9, 32'd9, OP_ACC, 1'b0, 1'b0); tick();
      drive(1'b1, 32'd1, 32'd1, OP_ACC, 1'b0, 1'b0); tick();
      idle(); tick(); tick(); tick(); tick();
      expectOut("acc.1", 32'd6, 1'b0);
      expectOut("acc.2", ACC_SECOND, 1'b0);
      expectOut("acc.3", 32'd1, 1'b0);
      check("acc.count", qd.size(), 64'd0);

      // Back-pressure with a fourth pair waiting at the input
      drive(1'b1, 32'd1, 32'd2, OP_UL, 1'b0, 1'b0); tick();
      drive(1'b1, 32'd3, 32'd4, OP_UL, 1'b0, 1'b0); tick();
      drive(1'b1, 32'd5, 32'd6, OP_UL, 1'b0, 1'b0); tick();
      drive(1'b1, 32'd7, 32'd8, OP_UL, 1'b0, 1'b0);
      I_BTk.n = 1'b1;
      #1;
      check("stall.n0", O_BTk.n, 64'd1);
      check("stall.d0", O_Result.d, 64'd2);
      tick();
      check("stall.n1", O_BTk.n, 64'd1);
      check("stall.v1", O_Result.v, 64'd1);
      check("stall.d1", O_Result.d, 64'd2);
      tick();
      check("stall.d2", O_Result.d, 64'd2);
      I_BTk.n = 1'b0;
      #1;
      check("stall.nrel", O_BTk.n, 64'd0);
      tick();
      idle();
      check("stall.da", O_Result.d, 64'd12); tick();
      check("stall.db", O_Result.d, 64'd30); tick();
      check("stall.dc", O_Result.d, 64'd56); tick();
      expectOut("stall.1", 32'd2, 1'b0);
      expectOut("stall.2", 32'd12, 1'b0);
      expectOut("stall.3", 32'd30, 1'b0);
      expectOut("stall.4", 32'd56, 1'b0);

      // Reset with tokens in flight and a non-zero accumulator
      drive(1'b1, 32'd3, 32'd3, OP_ACC, 1'b0, 1'b0); tick();
      drive(1'b1, 32'd2, 32'd2, OP_ACC, 1'b0, 1'b0); tick();
      idle(); tick();
      check("mid.v", O_Result.v, 64'd1);
      reset = 1'b1; tick();
      check("mid.result", O_Result, 64'd0);
      check("mid.btk", O_BTk, 64'd0);
      reset = 1'b0;
      tick(); tick(); tick(); tick();
      check("mid.none", qd.size(), 64'd0);
      drive(1'b1, 32'd9, 32'd9, OP_ACC, 1'b0, 1'b0); tick();
      drive(1'b1, 32'd1, 32'd1, OP_ACC, 1'b0, 1'b0); tick();
      idle(); tick(); tick(); tick(); tick();
      expectOut("mid.acc", 32'd1, 1'b0);
      check("end.count", qd.size(), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
